// File: rtl/clause_loader.sv
// Clause loader: packs a literal stream into 2-bit-per-variable clause rows and strobes them out one row at a time.
// Optional macro CLAUSE_LOADER_CLEAR_EN: on an early load end, zero-fill the remaining rows before finishing.
module clause_loader #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_VAR   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     lit_valid_i,
  output logic                     lit_ready_o,
  input  logic [WIDTH_VAR-1:0]     lit_var_i,
  input  logic                     lit_neg_i,
  input  logic                     lit_last_i,
  input  logic                     load_end_i,
  output logic [NUM_CLAUSES-1:0]   wr_o,
  output logic [2*NUM_VARS-1:0]    clause_o,
  output logic [WIDTH_C_LEN-1:0]   clause_len_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     full_o
);

  localparam int SW = $clog2(NUM_CLAUSES + 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
`ifdef CLAUSE_LOADER_CLEAR_EN
    CLEAR,
`endif
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [SW-1:0]           slot_q;
  logic [2*NUM_VARS-1:0]   buf_q;
  logic [WIDTH_C_LEN-1:0]  len_q;
  logic                    taut_q;
  logic                    full_q;

  logic                    accept;
  logic                    early_end;
  logic                    slot_wrap;
  logic [1:0]              lit_code;
  logic [1:0]              cur_pair;
  logic [NUM_CLAUSES-1:0]  one_hot;

  always_comb begin
    lit_code  = lit_neg_i ? 2'b01 : 2'b10;
    cur_pair  = buf_q[2*int'(lit_var_i) +: 2];
    accept    = (state_q == COLLECT) && lit_valid_i;
    // len of zero means nothing accepted yet; an arriving literal wins over load_end_i
    early_end = (state_q == COLLECT) && !accept && load_end_i && (len_q == '0);
    slot_wrap = (slot_q + SW'(1)) == SW'(NUM_CLAUSES);
    one_hot   = NUM_CLAUSES'(1) << slot_q;
  end

  always_comb begin
    state_d      = state_q;
    lit_ready_o  = 1'b0;
    wr_o         = '0;
    clause_o     = '0;
    clause_len_o = '0;
    busy_o       = (state_q != IDLE);
    done_o       = 1'b0;
    full_o       = full_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = COLLECT;
      end
      COLLECT: begin
        lit_ready_o = 1'b1;
        if (accept && lit_last_i) begin
          state_d = WRITE;
        end else if (early_end) begin
`ifdef CLAUSE_LOADER_CLEAR_EN
          state_d = CLEAR;
`else
          state_d = DONE;
`endif
        end
      end
      WRITE: begin
        wr_o = one_hot;
        if (!taut_q) begin
          clause_o     = buf_q;
          clause_len_o = len_q;
        end
        state_d = slot_wrap ? DONE : COLLECT;
      end
`ifdef CLAUSE_LOADER_CLEAR_EN
      CLEAR: begin
        wr_o = one_hot;
        if (slot_q == SW'(NUM_CLAUSES - 1)) state_d = DONE;
      end
`endif
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      taut_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            slot_q <= '0;
            buf_q  <= '0;
            len_q  <= '0;
            taut_q <= 1'b0;
            full_q <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (cur_pair == 2'b00) begin
              buf_q[2*int'(lit_var_i) +: 2] <= lit_code;
              len_q <= len_q + WIDTH_C_LEN'(1);
            end else if (cur_pair != lit_code) begin
              taut_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          slot_q <= slot_q + SW'(1);
          if (slot_wrap) begin
            full_q <= 1'b1;
          end else begin
            buf_q  <= '0;
            len_q  <= '0;
            taut_q <= 1'b0;
          end
        end
`ifdef CLAUSE_LOADER_CLEAR_EN
        CLEAR: slot_q <= slot_q + SW'(1);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_loader.sv
// Directed self-checking bench for clause_loader with hand-computed expected values.
module tb_clause_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        lit_valid_i;
  logic        lit_ready_o;
  logic [2:0]  lit_var_i;
  logic        lit_neg_i;
  logic        lit_last_i;
  logic        load_end_i;
  logic [7:0]  wr_o;
  logic [15:0] clause_o;
  logic [3:0]  clause_len_o;
  logic        busy_o;
  logic        done_o;
  logic        full_o;

  int n_checks = 0;
  int n_fail   = 0;

  clause_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .lit_valid_i  (lit_valid_i),
    .lit_ready_o  (lit_ready_o),
    .lit_var_i    (lit_var_i),
    .lit_neg_i    (lit_neg_i),
    .lit_last_i   (lit_last_i),
    .load_end_i   (load_end_i),
    .wr_o         (wr_o),
    .clause_o     (clause_o),
    .clause_len_o (clause_len_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .full_o       (full_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic send_lit(input int v, input bit neg, input bit last);
    lit_valid_i = 1'b1;
    lit_var_i   = 3'(v);
    lit_neg_i   = neg;
    lit_last_i  = last;
    step();
    lit_valid_i = 1'b0;
    lit_last_i  = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_wr"},    32'(wr_o), 32'h0);
    check({tag, "_cl"},    32'(clause_o), 32'h0);
    check({tag, "_len"},   32'(clause_len_o), 32'h0);
    check({tag, "_rdy"},   32'(lit_ready_o), 32'h0);
    check({tag, "_busy"},  32'(busy_o), 32'h0);
    check({tag, "_done"},  32'(done_o), 32'h0);
    check({tag, "_full"},  32'(full_o), 32'h0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; lit_valid_i = 1'b0; lit_var_i = '0;
    lit_neg_i = 1'b0; lit_last_i = 1'b0; load_end_i = 1'b0;
    step(); step();
    check_idle_zero("reset");
    rst = 1'b0;
    step();
    check("idle_busy", 32'(busy_o), 32'h0);

    // row 0: v2 pos, v5 neg
    do_start();
    check("start_busy", 32'(busy_o), 32'h1);
    check("start_rdy",  32'(lit_ready_o), 32'h1);
    check("start_nowr", 32'(wr_o), 32'h0);
    send_lit(2, 0, 0);
    send_lit(5, 1, 1);
    check("r0_wr",  32'(wr_o), 32'h01);
    check("r0_cl",  32'(clause_o), 32'h0420);
    check("r0_len", 32'(clause_len_o), 32'h2);
    check("r0_rdy", 32'(lit_ready_o), 32'h0);
    start_i = 1'b1;   // must be ignored outside IDLE
    step();
    start_i = 1'b0;
    check("post_wr",  32'(wr_o), 32'h0);
    check("post_cl",  32'(clause_o), 32'h0);
    check("post_rdy", 32'(lit_ready_o), 32'h1);

    // row 1: duplicate literal
    send_lit(1, 0, 0);
    send_lit(1, 0, 0);
    send_lit(3, 1, 1);
    check("r1_wr",  32'(wr_o), 32'h02);
    check("r1_cl",  32'(clause_o), 32'h0048);
    check("r1_len", 32'(clause_len_o), 32'h2);
    step();

    // row 2: tautology
    send_lit(0, 0, 0);
    send_lit(0, 1, 1);
    check("r2_wr",  32'(wr_o), 32'h04);
    check("r2_cl",  32'(clause_o), 32'h0);
    check("r2_len", 32'(clause_len_o), 32'h0);
    step();

    // row 3: literal arriving with load_end wins
    load_end_i = 1'b1;
    send_lit(4, 0, 0);
    load_end_i = 1'b0;
    check("prec_busy", 32'(busy_o), 32'h1);
    check("prec_rdy",  32'(lit_ready_o), 32'h1);
    send_lit(6, 0, 1);
    check("r3_wr",  32'(wr_o), 32'h08);
    check("r3_cl",  32'(clause_o), 32'h2200);
    check("r3_len", 32'(clause_len_o), 32'h2);
    step();

    // reset mid-clause discards it
    send_lit(1, 0, 0);
    rst = 1'b1;
    step();
    check_idle_zero("midrst");
    rst = 1'b0;
    do_start();
    send_lit(7, 1, 1);
    check("rs_wr",  32'(wr_o), 32'h01);
    check("rs_cl",  32'(clause_o), 32'h4000);
    check("rs_len", 32'(clause_len_o), 32'h1);
    step();
    send_lit(0, 0, 1);
    check("rs1_wr", 32'(wr_o), 32'h02);
    check("rs1_cl", 32'(clause_o), 32'h0002);
    step();

    // early end after two clauses
    load_end_i = 1'b1;
    step();
    load_end_i = 1'b0;
`ifdef CLAUSE_LOADER_CLEAR_EN
    for (int i = 2; i < 8; i++) begin
      check("clr_wr",   32'(wr_o), 32'(1) << i);
      check("clr_cl",   32'(clause_o), 32'h0);
      check("clr_len",  32'(clause_len_o), 32'h0);
      check("clr_done", 32'(done_o), 32'h0);
      step();
    end
`endif
    check("end_done", 32'(done_o), 32'h1);
    check("end_wr",   32'(wr_o), 32'h0);
    check("end_full", 32'(full_o), 32'h0);
    step();
    check("end_idle_done", 32'(done_o), 32'h0);
    check("end_idle_busy", 32'(busy_o), 32'h0);

    // eight single-literal clauses fill the array
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_lit(i, 0, 1);
      check("fill_wr",  32'(wr_o), 32'(1) << i);
      check("fill_cl",  32'(clause_o), 32'(2) << (2 * i));
      check("fill_len", 32'(clause_len_o), 32'h1);
      step();
    end
    check("full_done", 32'(done_o), 32'h1);
    check("full_flag", 32'(full_o), 32'h1);
    check("full_rdy",  32'(lit_ready_o), 32'h0);
    check("full_wr",   32'(wr_o), 32'h0);
    step();
    check("hold_done", 32'(done_o), 32'h0);
    check("hold_full", 32'(full_o), 32'h1);
    check("hold_busy", 32'(busy_o), 32'h0);
    step();
    check("hold2_full", 32'(full_o), 32'h1);
    do_start();
    check("restart_full", 32'(full_o), 32'h0);
    check("restart_rdy",  32'(lit_ready_o), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
